// File: rtl/axis2fifo_packer.sv
// Packs RATIO narrow AXI-stream beats into one wide word and writes it to a downstream FIFO
// through a two-entry output queue; a flush pulse emits the current partial word zero-padded.
module axis2fifo_packer #(
    parameter int IDSIZE = 1,
    parameter int RATIO  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       itvalid,
    output logic                       itready,
    input  logic [IDSIZE*8-1:0]        itdata,
    input  logic                       i_flush,
    input  logic                       i_full,
    output logic                       o_wen,
    output logic [IDSIZE*RATIO*8-1:0]  o_wdata,
    output logic                       flush_busy,
    output logic [15:0]                o_words
);

    // state       | meaning
    // S_ACC       | accumulating beats, flush requests accepted
    // S_FLUSH_WAIT| partial word held until the output queue has room
    typedef enum logic {S_ACC, S_FLUSH_WAIT} state_t;

    localparam int BW = IDSIZE * 8;
    localparam int OW = BW * RATIO;
    localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IW-1:0] LAST = IW'(RATIO - 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [OW-1:0]   acc, acc_nxt, acc_new;
    logic [OW-1:0]   q0, q1, push_data;
    logic [1:0]      qcount;
    logic            accept, pop, push, space, complete;

    assign itready    = ~rst & (state == S_ACC) & ((idx != LAST) | (qcount != 2'd2));
    assign o_wen      = ~rst & (qcount != 2'd0) & ~i_full;
    assign o_wdata    = q0;
    assign flush_busy = (state == S_FLUSH_WAIT);

    assign accept   = itvalid & itready;
    assign pop      = o_wen;
    assign space    = (qcount != 2'd2) | pop;
    assign complete = accept & (idx == LAST);

    always_comb begin
        acc_new = acc;
        if (accept) begin
            for (int l = 0; l < RATIO; l++) begin
                if (idx == IW'(l)) acc_new[l*BW +: BW] = itdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        acc_nxt   = acc;
        push      = 1'b0;
        push_data = acc_new;
        case (state)
            S_ACC: begin
                if (complete) begin
                    push    = 1'b1;
                    idx_nxt = '0;
                    acc_nxt = '0;
                end else if (accept) begin
                    idx_nxt = idx + IW'(1);
                    acc_nxt = acc_new;
                end
                // a flush that coincides with the completing beat adds no extra word
                if (i_flush && !complete && (accept || idx != '0)) begin
                    if (space) begin
                        push    = 1'b1;
                        idx_nxt = '0;
                        acc_nxt = '0;
                    end else begin
                        state_nxt = S_FLUSH_WAIT;
                    end
                end
            end
            S_FLUSH_WAIT: begin
                if (space) begin
                    push      = 1'b1;
                    push_data = acc;
                    idx_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ACC;
            idx   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            acc   <= acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q0     <= '0;
            q1     <= '0;
            qcount <= 2'd0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    q0     <= q1;
                    qcount <= qcount - 2'd1;
                end
                2'b10: begin
                    if (qcount == 2'd0) q0 <= push_data;
                    else                q1 <= push_data;
                    qcount <= qcount + 2'd1;
                end
                2'b11: begin
                    if (qcount == 2'd1) begin
                        q0 <= push_data;
                    end else begin
                        q0 <= q1;
                        q1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        o_words <= 16'd0;
        else if (o_wen) o_words <= o_words + 16'd1;
    end

endmodule

// File: tb/tb_axis2fifo_packer.sv
// Bench for axis2fifo_packer (IDSIZE=1, RATIO=4): directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model of the packing rules.
module tb_axis2fifo_packer;

    localparam int IDSIZE = 1;
    localparam int RATIO  = 4;

    logic        clk = 1'b0;
    logic        rst, itvalid, itready, i_flush, i_full, o_wen, flush_busy;
    logic [7:0]  itdata;
    logic [31:0] o_wdata;
    logic [15:0] o_words;

    axis2fifo_packer #(.IDSIZE(IDSIZE), .RATIO(RATIO)) dut (
        .clk(clk), .rst(rst), .itvalid(itvalid), .itready(itready), .itdata(itdata),
        .i_flush(i_flush), .i_full(i_full), .o_wen(o_wen), .o_wdata(o_wdata),
        .flush_busy(flush_busy), .o_words(o_words)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  part[$];
    logic [31:0] mq[$];
    logic [31:0] wlog[$];
    bit          m_busy;
    logic [15:0] m_words;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] packed_word();
        logic [31:0] w = '0;
        foreach (part[i]) w[i*8 +: 8] = part[i];
        return w;
    endfunction

    task automatic cycle(input logic v, input logic [7:0] d, input logic fl, input logic fu,
                         input logic r);
        bit exp_rdy, exp_wen, done;
        @(negedge clk);
        itvalid = v; itdata = d; i_flush = fl; i_full = fu; rst = r;
        #1;
        exp_rdy = !r && !m_busy && (part.size() != RATIO - 1 || mq.size() < 2);
        exp_wen = !r && mq.size() != 0 && !fu;
        check("itready", itready, exp_rdy);
        check("o_wen", o_wen, exp_wen);
        if (exp_wen && o_wen) check("o_wdata", o_wdata, mq[0]);
        check("flush_busy", flush_busy, m_busy);
        check("o_words", o_words, m_words);
        if (o_wen) wlog.push_back(o_wdata);
        @(posedge clk);
        if (r) begin
            part.delete(); mq.delete(); m_busy = 0; m_words = '0;
        end else begin
            done = 0;
            if (exp_wen) begin
                void'(mq.pop_front());
                m_words++;
            end
            if (m_busy) begin
                if (mq.size() < 2) begin
                    mq.push_back(packed_word());
                    part.delete();
                    m_busy = 0;
                end
            end else begin
                if (v && exp_rdy) begin
                    part.push_back(d);
                    if (part.size() == RATIO) begin
                        mq.push_back(packed_word());
                        part.delete();
                        done = 1;
                    end
                end
                if (fl && !done && part.size() != 0) begin
                    if (mq.size() < 2) begin
                        mq.push_back(packed_word());
                        part.delete();
                    end else begin
                        m_busy = 1;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic fu);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, fu, 1'b0);
    endtask

    task automatic start();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        wlog.delete();
    endtask

    initial begin
        rst = 1'b1; itvalid = 1'b0; itdata = '0; i_flush = 1'b0; i_full = 1'b0;
        m_busy = 0; m_words = '0;
        repeat (2) @(posedge clk);

        // back-to-back beats into one word
        start();
        cycle(1, 8'h11, 0, 0, 0); cycle(1, 8'h22, 0, 0, 0);
        cycle(1, 8'h33, 0, 0, 0); cycle(1, 8'h44, 0, 0, 0);
        idle(2, 0);
        #2;
        check("basic_nwr", wlog.size(), 1);
        if (wlog.size() > 0) check("basic_word", wlog[0], 32'h4433_2211);
        check("basic_count", o_words, 16'd1);

        // downstream full: queue fills, then drains on release
        start();
        for (int i = 1; i <= 12; i++) cycle(1, 8'(i), 0, 1, 0);
        #2;
        check("full_rdy", itready, 0);
        check("full_nwr", wlog.size(), 0);
        idle(3, 0);
        #2;
        check("drain_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("drain_w0", wlog[0], 32'h0403_0201);
            check("drain_w1", wlog[1], 32'h0807_0605);
        end
        check("drain_rdy", itready, 1);

        // partial flush then an empty flush
        start();
        cycle(1, 8'hAA, 0, 0, 0); cycle(1, 8'hBB, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        idle(2, 0);
        cycle(0, 8'h00, 1, 0, 0);
        idle(2, 0);
        #2;
        check("flush_nwr", wlog.size(), 1);
        if (wlog.size() > 0) check("flush_word", wlog[0], 32'h0000_BBAA);

        // flush coinciding with the completing beat
        start();
        cycle(1, 8'h02, 0, 0, 0); cycle(1, 8'h03, 0, 0, 0); cycle(1, 8'h04, 0, 0, 0);
        cycle(1, 8'h01, 1, 0, 0);
        idle(3, 0);
        #2;
        check("coinc_nwr", wlog.size(), 1);
        if (wlog.size() > 0) check("coinc_word", wlog[0], 32'h0104_0302);

        // flush with a full queue waits for space
        start();
        for (int i = 1; i <= 10; i++) cycle(1, 8'(i), 0, 1, 0);
        cycle(0, 8'h00, 1, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);
        #2;
        check("busy_set", flush_busy, 1);
        check("busy_rdy", itready, 0);
        idle(5, 0);
        #2;
        check("busy_nwr", wlog.size(), 3);
        if (wlog.size() == 3) check("busy_word", wlog[2], 32'h0000_0A09);
        check("busy_clr", flush_busy, 0);

        // reset mid-operation discards everything
        start();
        for (int i = 1; i <= 6; i++) cycle(1, 8'(i + 8'h10), 0, 1, 0);
        cycle(0, 8'h00, 0, 0, 1);
        idle(3, 0);
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, 0);
        idle(2, 0);
        #2;
        check("rst_nwr", wlog.size(), 1);
        if (wlog.size() > 0) check("rst_word", wlog[0], 32'h0403_0201);
        check("rst_count", o_words, 16'd1);

        // random traffic
        start();
        begin
            logic fu = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) fu = ~fu;
                cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 11) == 0,
                      fu, $urandom_range(0, 599) == 0);
            end
        end
        idle(4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
